strip_timestamp: RTL and testbench
==================================

# strip_timestamp

Receive-side counterpart of `set_timestamp`. Accepts an AXI4-Stream Ethernet frame whose trailing `TIMESTAMP_WIDTH` bits are a timestamp footer. Forwards the frame without the footer on `m_axis_*` and presents the extracted timestamp on a separate handshake channel. It sits at the ingress of the ATS eligibility logic, downstream of any link that carries `set_timestamp` output.

## Interface
Parameters:
- `DATA_WIDTH`, 8: stream data width in bits; a multiple of 8.
- `TIMESTAMP_WIDTH`, 72: footer width in bits; a multiple of `DATA_WIDTH`.
- `TS_BEATS`: derived, `TIMESTAMP_WIDTH/DATA_WIDTH`; must be at least 1.

Ports (reset rstn, synchronous, active-low; clock clk):
- `clk` input 1: clock.
- `rstn` input 1: synchronous active-low reset.
- `s_axis_tdata/tkeep/tvalid/tready/tlast` input/input/input/output/input, widths `DATA_WIDTH`/`DATA_WIDTH/8`/1/1/1: frame followed by its footer.
- `m_axis_tdata/tkeep/tvalid/tready/tlast` output/output/output/input/output, same widths: frame only.
- `m_ts_tdata` output `TIMESTAMP_WIDTH`: extracted timestamp.
- `m_ts_tvalid` output 1, `m_ts_tready` input 1: timestamp handshake.
- `runt_error` output 1: one-cycle pulse when an input packet has no frame bytes.

## Operation
- Delay line holds `TS_BEATS` beats (data, keep) with occupancy `count` in the range 0..`TS_BEATS`.
- Accept condition (`s_axis_tready`):
  - When `count<TS_BEATS`: accept.
  - When `count==TS_BEATS`: accept only if `(!m_axis_tvalid || m_axis_tready)`.
  - In addition, when `count==TS_BEATS` and `s_axis_tlast` is high: accept only if `(!m_ts_tvalid || m_ts_tready)`.
  - `s_axis_tready` is combinational from this condition.
- Accepted beat, not last, `count<TS_BEATS`: push the beat; increment `count`.
- Accepted beat, not last, `count==TS_BEATS`: pop the oldest beat into the output register with `tlast=0`; push the new beat.
- Accepted last beat, `count==TS_BEATS`:
  - Pop the oldest beat into the output register with `m_axis_tlast=1`.
  - The remaining `TS_BEATS-1` beats plus the new beat form the timestamp, which loads into `m_ts_tdata`, and `m_ts_tvalid` is set to 1.
  - `count` returns to 0.
- Accepted last beat, `count<TS_BEATS` (runt, total length at most `TS_BEATS` beats): discard everything, set `count` to 0, pulse `runt_error`. Nothing is emitted on either output.
- Footer byte order: the first footer beat carries the most-significant `DATA_WIDTH` bits of the timestamp (big-endian, network order). This matches `set_timestamp`.
- Footer `tkeep` is ignored. Frame `tkeep` passes through unchanged.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `m_axis_tkeep=0`, `m_ts_tvalid=0`, `m_ts_tdata=0`, `runt_error=0`, `count=0`.
- Output latency: frame beat k appears on `m_axis` one cycle after input beat k+`TS_BEATS` is accepted.
- The last frame beat and `m_ts_tvalid` rise in the same cycle, the cycle after the input `tlast` is accepted.
- Throughput: one beat per cycle while both readies are held high. There are no bubbles between back-to-back frames.
- Output registers hold their values while `tvalid` is high and `tready` is low.
- `m_ts_tvalid` clears on a handshake unless a new timestamp loads in the same cycle.
- Simultaneous `m_ts` handshake and new timestamp load: the new value wins and `m_ts_tvalid` stays 1.
- Reset mid-frame: the partial frame is lost and no `tlast` is emitted. The first beat accepted after reset is treated as a frame start.

## Configuration
- `STRIP_TIMESTAMP_RESIDENCE_EN`: when defined, the block adds:
  - input `ats_scheduler_timer` [`TIMESTAMP_WIDTH`].
  - output `m_ts_residence` [`TIMESTAMP_WIDTH`] = (timer − timestamp) mod 2^`TIMESTAMP_WIDTH`. It is computed with the timer value in the cycle the input `tlast` is accepted and is qualified by `m_ts_tvalid`.
- Without the macro, neither port exists and no subtractor is built.

## Structure
- Shared package `ts_footer_pkg`:
  - `TS_BEATS` function.
  - Byte-order constant.
  - Footer-to-timestamp packing function. `set_timestamp` reuses it.
- One sub-module, `timestamp_footer_delay`: the `TS_BEATS`-deep shift register with occupancy counter and parallel read for footer extraction. The handshake and output registers live in the top module.

## Test plan
All scenarios use `DATA_WIDTH=8`, `TIMESTAMP_WIDTH=72`, `TS_BEATS=9`.
1. 64-byte frame plus footer `0x00_0000_0000_0000_1F40`, readies held at 1 → 64 output bytes, `tlast` on byte 64, `m_ts_tdata=0x1F40` in the same cycle, `runt_error` stays 0.
2. Back-to-back 60-byte and 1514-byte frames, readies held at 1 → `s_axis_tready` never drops, both frames are byte-exact, and two timestamps come out in order.
3. Footer-only 9-byte packet, then a 5-byte packet → no `m_axis` or `m_ts` output, and one `runt_error` pulse per packet.
4. `m_ts_tready=0` holds the first timestamp → the second frame's `tlast` stalls with `s_axis_tready=0`. After `m_ts_tready` rises, the second timestamp is delivered and no data is lost.
5. `rstn` asserted after 20 bytes of a frame → all outputs are 0 the next cycle, and the following 64-byte frame is byte-exact.
6. With the macro defined:
   - timestamp `0x1F40`, timer `0x3E80` → `m_ts_residence=0x1F40`.
   - timestamp 2^72−8000, timer 8000 → `m_ts_residence=16000`.

Source files
------------

// File: rtl/ts_footer_pkg.sv
// Timestamp footer helpers shared by set_timestamp and strip_timestamp.
// Footer beats travel most-significant first (network order).
package ts_footer_pkg;

    localparam bit FOOTER_MSB_FIRST = 1'b1;

    function automatic int ts_beats(input int data_width, input int timestamp_width);
        return timestamp_width / data_width;
    endfunction

    // Timestamp bit offset of footer beat idx (idx 0 = first footer beat on the wire).
    function automatic int footer_pack_lsb(input int idx, input int n_beats, input int data_width);
        return FOOTER_MSB_FIRST ? (n_beats - 1 - idx) * data_width : idx * data_width;
    endfunction

endpackage

// File: rtl/strip_timestamp_if.sv
// AXI4-Stream beat bundle (data, keep, last) with valid/ready.
// master drives the beat, slave returns tready.
interface strip_timestamp_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/timestamp_footer_delay.sv
// Purpose: TS_BEATS-deep beat shift register with occupancy, parallel read for footer extraction.
// Latency: a pushed beat reaches head after TS_BEATS pushes; head is read combinationally.
// Backpressure: none here; the caller only pushes/clears on accepted beats.
module timestamp_footer_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int TS_BEATS   = 9
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                push,
    input  logic                                clear,
    input  logic [DATA_WIDTH-1:0]               in_dat,
    input  logic [DATA_WIDTH/8-1:0]             in_keep,
    output logic [TS_BEATS-1:0][DATA_WIDTH-1:0] dat,
    output logic [DATA_WIDTH/8-1:0]             head_keep,
    output logic                                full
);
    localparam int CW = $clog2(TS_BEATS + 1);

    logic [TS_BEATS-1:0][DATA_WIDTH-1:0]   dat_q;
    logic [TS_BEATS-1:0][DATA_WIDTH/8-1:0] keep_q;
    logic [CW-1:0]                         count;

    assign full      = (count == CW'(TS_BEATS));
    assign dat       = dat_q;
    assign head_keep = keep_q[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end
    end

    // Newest beat enters at the top; once full, entry 0 is the oldest and leaves on the next push.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < TS_BEATS - 1; i++) begin
                dat_q[i]  <= dat_q[i+1];
                keep_q[i] <= keep_q[i+1];
            end
            dat_q[TS_BEATS-1]  <= in_dat;
            keep_q[TS_BEATS-1] <= in_keep;
        end
    end

endmodule

// File: rtl/strip_timestamp.sv
// Purpose: strip the trailing timestamp footer from a frame, emit it on m_ts (optional residence: STRIP_TIMESTAMP_RESIDENCE_EN).
// Latency: frame beat k leaves 1 cycle after input beat k+TS_BEATS; timestamp rises with the last frame beat.
// Backpressure: s_axis stalls when the delay line is full and m_axis (or m_ts, on tlast) cannot take a new value.
module strip_timestamp
    import ts_footer_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int TIMESTAMP_WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       rstn,
    strip_timestamp_if.slave           s_axis,
    strip_timestamp_if.master          m_axis,
    output logic [TIMESTAMP_WIDTH-1:0] m_ts_tdata,
    output logic                       m_ts_tvalid,
    input  logic                       m_ts_tready,
    output logic                       runt_error
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
    ,
    input  logic [TIMESTAMP_WIDTH-1:0] ats_scheduler_timer,
    output logic [TIMESTAMP_WIDTH-1:0] m_ts_residence
`endif
);
    localparam int TS_BEATS = ts_beats(DATA_WIDTH, TIMESTAMP_WIDTH);

    logic [TS_BEATS-1:0][DATA_WIDTH-1:0] dly_dat;
    logic [DATA_WIDTH/8-1:0]             head_keep;
    logic                                full;
    logic                                s_rdy;
    logic                                accept;
    logic                                push;
    logic                                clear;
    logic                                ts_load;
    logic [TIMESTAMP_WIDTH-1:0]          ts_next;

    assign s_rdy = !full ||
                   ((!m_axis.tvalid || m_axis.tready) &&
                    (!s_axis.tlast || !m_ts_tvalid || m_ts_tready));

    assign s_axis.tready = s_rdy;
    assign accept        = s_axis.tvalid && s_rdy;
    assign push          = accept && !s_axis.tlast;
    assign clear         = accept && s_axis.tlast;
    assign ts_load       = clear && full;

    timestamp_footer_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .TS_BEATS   (TS_BEATS)
    ) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .clear     (clear),
        .in_dat    (s_axis.tdata),
        .in_keep   (s_axis.tkeep),
        .dat       (dly_dat),
        .head_keep (head_keep),
        .full      (full)
    );

    // Footer = delay entries 1..TS_BEATS-1 (oldest first) followed by the incoming last beat.
    always_comb begin
        ts_next = '0;
        for (int i = 0; i < TS_BEATS - 1; i++) begin
            ts_next[footer_pack_lsb(i, TS_BEATS, DATA_WIDTH) +: DATA_WIDTH] = dly_dat[i+1];
        end
        ts_next[footer_pack_lsb(TS_BEATS - 1, TS_BEATS, DATA_WIDTH) +: DATA_WIDTH] = s_axis.tdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
            m_ts_tvalid   <= 1'b0;
            m_ts_tdata    <= '0;
            runt_error    <= 1'b0;
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
            m_ts_residence <= '0;
`endif
        end else begin
            runt_error <= clear && !full;

            if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            if (accept && full) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= dly_dat[0];
                m_axis.tkeep  <= head_keep;
                m_axis.tlast  <= s_axis.tlast;
            end

            // A load in the same cycle as a handshake overrides the clear.
            if (m_ts_tready) begin
                m_ts_tvalid <= 1'b0;
            end
            if (ts_load) begin
                m_ts_tvalid <= 1'b1;
                m_ts_tdata  <= ts_next;
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
                m_ts_residence <= ats_scheduler_timer - ts_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_strip_timestamp.sv
// Randomized and directed bench for strip_timestamp against a packet-level queue model.
module tb_strip_timestamp;
    localparam int DW = 8;
    localparam int TW = 72;
    localparam int NB = TW / DW;

    typedef struct {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        logic            l;
    } beat_t;

    typedef struct {
        logic [TW-1:0] ts;
        logic [TW-1:0] res;
    } tsx_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    strip_timestamp_if #(.DATA_WIDTH(DW)) s_if ();
    strip_timestamp_if #(.DATA_WIDTH(DW)) m_if ();

    logic [TW-1:0] ts_dat;
    logic          ts_vld;
    logic          ts_rdy;
    logic          runt;
    logic [TW-1:0] ats_timer;
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
    logic [TW-1:0] ts_res;
`endif

    strip_timestamp #(.DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .m_ts_tdata  (ts_dat),
        .m_ts_tvalid (ts_vld),
        .m_ts_tready (ts_rdy),
        .runt_error  (runt)
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
        ,
        .ats_scheduler_timer (ats_timer),
        .m_ts_residence      (ts_res)
`endif
    );

    beat_t exp_q[$];
    tsx_t  ts_q[$];
    bit    beat_due[int];
    bit    ts_rise_at[int];
    bit    runt_at[int];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int stalls = 0;
    int obs_beats = 0;
    int obs_ts = 0;
    int obs_runts = 0;
    int rdy_mode = 0;
    bit mon_en = 1'b0;
    bit drv_last = 1'b0;
    logic [TW-1:0] obs_last_ts = '0;
    logic [TW-1:0] obs_last_res = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready generator: 0 = both held high, 1 = random, 2 = left to directed code.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) begin
            m_if.tready = ($urandom_range(0, 3) != 0);
            ts_rdy      = ($urandom_range(0, 2) != 0);
        end else if (rdy_mode == 0) begin
            m_if.tready = 1'b1;
            ts_rdy      = 1'b1;
        end
    end

    // Compare process: checks every cycle against the queues and per-cycle expectations.
    logic                 p_mv, p_mr, p_tv, p_tr;
    logic [DW+DW/8:0]     p_m;
    logic [TW-1:0]        p_t;
    beat_t                e_b;
    tsx_t                 e_t;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (p_mv && !p_mr)
                chk("m_axis_hold", {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast}, {1'b1, p_m});
            if (p_tv && !p_tr)
                chk("m_ts_hold", {ts_vld, ts_dat}, {1'b1, p_t});
            if (beat_due.exists(cyc))
                chk("m_axis_latency", m_if.tvalid, 1'b1);
            if (ts_rise_at.exists(cyc))
                chk("ts_with_tlast", {ts_vld, m_if.tvalid, m_if.tlast}, 3'b111);
            chk("runt_error", runt, runt_at.exists(cyc));
            if (runt) obs_runts++;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    chk("m_axis_unexpected", m_if.tvalid, 1'b0);
                end else begin
                    e_b = exp_q.pop_front();
                    chk("m_axis_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, {e_b.d, e_b.k, e_b.l});
                    obs_beats++;
                end
            end
            if (ts_vld && ts_rdy) begin
                if (ts_q.size() == 0) begin
                    chk("m_ts_unexpected", ts_vld, 1'b0);
                end else begin
                    e_t = ts_q.pop_front();
                    chk("m_ts_tdata", ts_dat, e_t.ts);
                    obs_ts++;
                    obs_last_ts = ts_dat;
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
                    chk("m_ts_residence", ts_res, e_t.res);
                    obs_last_res = ts_res;
`endif
                end
            end
        end
        p_mv = m_if.tvalid;
        p_mr = m_if.tready;
        p_m  = {m_if.tdata, m_if.tkeep, m_if.tlast};
        p_tv = ts_vld;
        p_tr = ts_rdy;
        p_t  = ts_dat;
    end

    // Sends n beats; the last NB carry ts MSB-first. abort drops tlast (partial frame).
    task automatic send_pkt(input int n, input logic [TW-1:0] ts, input logic [TW-1:0] timer,
                            input int gap_pct, input bit abort);
        logic [DW-1:0]   d[];
        logic [DW/8-1:0] kp[];
        bit              isrunt;
        int              w;
        beat_t           b;
        tsx_t            tx;
        d  = new[n];
        kp = new[n];
        isrunt = (n <= NB) && !abort;
        for (int j = 0; j < n; j++) begin
            d[j]  = DW'($urandom);
            kp[j] = 1'($urandom_range(0, 1));
            if (j >= n - NB) d[j] = ts[(n-1-j)*DW +: DW];
        end
        ats_timer = timer;
        for (int j = 0; j < n; j++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d[j];
            s_if.tkeep  = kp[j];
            s_if.tlast  = (j == n - 1) && !abort;
            drv_last    = s_if.tlast;
            w = 0;
            forever begin
                @(negedge clk);
                if (s_if.tready) break;
                stalls++;
                w++;
                if (w > 2000) begin
                    chk("s_axis_tready_timeout", s_if.tready, 1'b1);
                    s_if.tvalid = 1'b0;
                    drv_last    = 1'b0;
                    return;
                end
            end
            if (!isrunt && j >= NB) begin
                b.d = d[j-NB];
                b.k = kp[j-NB];
                b.l = (j == n - 1) && !abort;
                exp_q.push_back(b);
                beat_due[cyc+1] = 1'b1;
            end
            if (j == n - 1 && !abort) begin
                if (isrunt) begin
                    runt_at[cyc+1] = 1'b1;
                end else begin
                    tx.ts  = ts;
                    tx.res = timer - ts;
                    ts_q.push_back(tx);
                    ts_rise_at[cyc+1] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        drv_last    = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || ts_q.size() != 0) && w < 5000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_done", w < 5000, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, t0, r0, w;
        logic [TW-1:0] tsv, tmr;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        ts_rdy      = 1'b1;
        ats_timer   = '0;
        rstn        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m_axis", {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast}, 0);
        chk("reset_m_ts", {ts_vld, ts_dat}, 0);
        chk("reset_runt", runt, 0);
        chk("reset_s_tready", s_if.tready, 1);
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // 64-byte frame, footer 0x1F40
        b0 = obs_beats; r0 = obs_runts;
        send_pkt(64 + NB, 72'h1F40, 72'h3E80, 0, 0);
        drain();
        chk("t1_beats", obs_beats - b0, 64);
        chk("t1_ts", obs_last_ts, 72'h1F40);
        chk("t1_no_runt", obs_runts - r0, 0);
`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
        chk("t1_residence", obs_last_res, 72'h1F40);
`endif

        // back-to-back 60 and 1514 byte frames
        b0 = obs_beats; t0 = obs_ts; stalls = 0;
        send_pkt(60 + NB, 72'h12_3456_789A_BCDE_F011, 72'h0, 0, 0);
        send_pkt(1514 + NB, 72'hFE_DCBA_9876_5432_10AA, 72'h0, 0, 0);
        chk("t2_no_stall", stalls, 0);
        drain();
        chk("t2_beats", obs_beats - b0, 60 + 1514);
        chk("t2_ts_count", obs_ts - t0, 2);
        chk("t2_last_ts", obs_last_ts, 72'hFE_DCBA_9876_5432_10AA);

        // runts: footer only, then 5 bytes
        b0 = obs_beats; t0 = obs_ts; r0 = obs_runts;
        send_pkt(9, 72'h55, 72'h0, 0, 0);
        send_pkt(5, 72'h66, 72'h0, 0, 0);
        drain();
        chk("t3_runts", obs_runts - r0, 2);
        chk("t3_no_beats", obs_beats - b0, 0);
        chk("t3_no_ts", obs_ts - t0, 0);

        // held timestamp stalls the next frame's tlast
        rdy_mode = 2;
        m_if.tready = 1'b1;
        ts_rdy = 1'b0;
        b0 = obs_beats; t0 = obs_ts;
        send_pkt(20 + NB, 72'hA1, 72'h0, 0, 0);
        fork
            send_pkt(30 + NB, 72'hB2, 72'h0, 0, 0);
            begin
                w = 0;
                while (!drv_last && w < 1000) begin
                    @(negedge clk);
                    w++;
                end
                chk("t4_reached_tlast", drv_last, 1);
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_s_tready_stall", s_if.tready, 0);
                    chk("t4_ts_held", {ts_vld, ts_dat}, {1'b1, 72'hA1});
                end
                @(posedge clk);
                #1;
                ts_rdy = 1'b1;
            end
        join
        rdy_mode = 0;
        drain();
        chk("t4_ts_count", obs_ts - t0, 2);
        chk("t4_last_ts", obs_last_ts, 72'hB2);
        chk("t4_beats", obs_beats - b0, 50);

        // reset after 20 bytes of a frame
        send_pkt(20, 72'h0, 72'h0, 0, 1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_reset_m_axis", {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast}, 0);
        chk("t5_reset_m_ts", {ts_vld, ts_dat, runt}, 0);
        chk("t5_partial_emitted", exp_q.size(), 0);
        exp_q.delete();
        ts_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        b0 = obs_beats;
        send_pkt(64 + NB, 72'h77_0000_0000_0000_1234, 72'h0, 0, 0);
        drain();
        chk("t5_beats", obs_beats - b0, 64);
        chk("t5_ts", obs_last_ts, 72'h77_0000_0000_0000_1234);

`ifdef STRIP_TIMESTAMP_RESIDENCE_EN
        tsv = '0;
        tsv = tsv - 72'd8000;
        send_pkt(10 + NB, tsv, 72'd8000, 0, 0);
        drain();
        chk("t6_residence_wrap", obs_last_res, 72'd16000);
`endif

        // randomized traffic, random gaps and readies
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            tsv[71:64] = 8'($urandom);
            tsv[63:32] = $urandom;
            tsv[31:0]  = $urandom;
            tmr[71:64] = 8'($urandom);
            tmr[63:32] = $urandom;
            tmr[31:0]  = $urandom;
            send_pkt($urandom_range(1, 40), tsv, tmr, 20, 0);
        end
        rdy_mode = 0;
        drain();
        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_ts_q_empty", ts_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
